// File: rtl/data_router_pkg.sv
// Shared defaults and helpers for the strobe-driven data router.
package data_router_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CH_SEL_W = 1;
  localparam int DEF_DEPTH    = 2;
  localparam int DEF_N_CH     = 2 ** DEF_CH_SEL_W;

  // Ceiling log2 for elaboration-time sizing of pointers and counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/data_router_chan_fifo.sv
// Show-ahead per-channel FIFO; a pop on a full FIFO frees the slot for a
// same-cycle push, so full+push+pop accepts the word.
module chan_fifo
  import data_router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              pop;
  logic              wr;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];
  assign pop   = valid & pop_ready;
  assign wr    = push & (~full | pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_router.sv
// Strobe-synchronised demux into N_CH buffered channels with sticky
// overflow flags.
module data_router
  import data_router_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CH_SEL_W = DEF_CH_SEL_W,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                DATA,
  input  logic                             data_sb,
  output logic [(2**CH_SEL_W)*DATA_W-1:0]  ch_data,
  output logic [(2**CH_SEL_W)-1:0]         ch_valid,
  input  logic [(2**CH_SEL_W)-1:0]         ch_ready,
  output logic [(2**CH_SEL_W)-1:0]         ch_ovf,
  input  logic                             ovf_clr
);

  localparam int N_CH = 2 ** CH_SEL_W;

  logic                s1, s2, s3;
  logic                push;
  logic [CH_SEL_W-1:0] sel;
  logic [N_CH-1:0]     push_vec;
  logic [N_CH-1:0]     full;
  logic [N_CH-1:0]     ovf_evt;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= data_sb;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push = s2 & ~s3;
  assign sel  = DATA[DATA_W-1 -: CH_SEL_W];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign push_vec[i] = push & (sel == CH_SEL_W'(i));
    // Full implies valid, so a ready consumer always makes room this cycle.
    assign ovf_evt[i]  = push_vec[i] & full[i] & ~ch_ready[i];

    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[i]),
      .din       (DATA),
      .pop_ready (ch_ready[i]),
      .dout      (ch_data[i*DATA_W +: DATA_W]),
      .valid     (ch_valid[i]),
      .full      (full[i])
    );
  end

  // Sticky overflow flags; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) ch_ovf <= '0;
    else     ch_ovf <= (ch_ovf & ~{N_CH{ovf_clr}}) | ovf_evt;
  end

endmodule

// File: tb/tb_data_router.sv
// Directed bench for data_router: default 2-channel instance plus a
// 4-channel instance for the select-width sweep.
module tb_data_router;

  logic        clk = 1'b0;
  logic        rst;
  // default instance (DATA_W=8, CH_SEL_W=1, DEPTH=2)
  logic [7:0]  data;
  logic        sb;
  logic [15:0] ch_data;
  logic [1:0]  ch_valid, ch_ready, ch_ovf;
  logic        ovf_clr;
  // four-channel instance
  logic [7:0]  data4;
  logic        sb4;
  logic [31:0] ch_data4;
  logic [3:0]  ch_valid4, ch_ready4, ch_ovf4;
  logic        ovf_clr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_router dut (
    .clk(clk), .rst(rst), .DATA(data), .data_sb(sb),
    .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_ovf(ch_ovf), .ovf_clr(ovf_clr)
  );

  data_router #(.DATA_W(8), .CH_SEL_W(2), .DEPTH(2)) dut4 (
    .clk(clk), .rst(rst), .DATA(data4), .data_sb(sb4),
    .ch_data(ch_data4), .ch_valid(ch_valid4), .ch_ready(ch_ready4),
    .ch_ovf(ch_ovf4), .ovf_clr(ovf_clr4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One strobe pulse: high 3 edges (push on the third), low 2 edges.
  task automatic send(input logic [7:0] w);
    data = w; sb = 1'b1;
    step(); step(); step();
    sb = 1'b0;
    step(); step();
  endtask

  task automatic send4(input logic [7:0] w);
    data4 = w; sb4 = 1'b1;
    step(); step(); step();
    sb4 = 1'b0;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; data = '0; sb = 1'b0; ch_ready = '0; ovf_clr = 1'b0;
    data4 = '0; sb4 = 1'b0; ch_ready4 = '0; ovf_clr4 = 1'b0;
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_valid", 32'(ch_valid), 32'h0);
    check("rst_ovf",   32'(ch_ovf),   32'h0);
    check("rst_data",  32'(ch_data),  32'h0);

    // basic route: 3-edge latency
    data = 8'h85; sb = 1'b1;
    step(); check("lat_e0", 32'(ch_valid), 32'h0);
    step(); check("lat_e1", 32'(ch_valid), 32'h0);
    step(); check("lat_e2", 32'(ch_valid), 32'h2);
    check("route_85", 32'(ch_data[15:8]), 32'h85);
    sb = 1'b0; step(); step();
    send(8'h12);
    check("route_12_valid", 32'(ch_valid), 32'h3);
    check("route_12_data",  32'(ch_data[7:0]), 32'h12);

    // drain both
    ch_ready = 2'b11; step(); ch_ready = 2'b00;
    check("drain", 32'(ch_valid), 32'h0);

    // long strobe: one push only
    data = 8'h81; sb = 1'b1;
    repeat (20) step();
    sb = 1'b0; step(); step();
    check("long_valid", 32'(ch_valid), 32'h2);
    check("long_data",  32'(ch_data[15:8]), 32'h81);
    ch_ready = 2'b10; step(); ch_ready = 2'b00;
    check("long_occ1", 32'(ch_valid), 32'h0);

    // overflow with no consumer
    send(8'h01); send(8'h02); send(8'h03);
    check("ovf_set",  32'(ch_ovf), 32'h1);
    check("ovf_head", 32'(ch_data[7:0]), 32'h01);
    ch_ready = 2'b01;
    step(); check("ovf_pop2", 32'(ch_data[7:0]), 32'h02);
    check("ovf_pop2_v", 32'(ch_valid), 32'h1);
    step(); check("ovf_empty", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00;
    check("ovf_sticky", 32'(ch_ovf), 32'h1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", 32'(ch_ovf), 32'h0);

    // full + simultaneous pop accepts the word
    send(8'h01); send(8'h02);
    data = 8'h03; sb = 1'b1;
    step(); step();
    ch_ready = 2'b01;
    step();
    check("fp_head02", 32'(ch_data[7:0]), 32'h02);
    check("fp_noovf",  32'(ch_ovf), 32'h0);
    step(); check("fp_head03", 32'(ch_data[7:0]), 32'h03);
    check("fp_valid03", 32'(ch_valid[0]), 32'h1);
    step(); check("fp_empty", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00; sb = 1'b0; step(); step();

    // four-channel sweep
    send4(8'h00); send4(8'h40); send4(8'h80); send4(8'hC0);
    check("sw_valid", 32'(ch_valid4), 32'hF);
    check("sw_data",  ch_data4, 32'hC0804000);
    send4(8'h01); send4(8'h41); send4(8'h81);
    ch_ready4 = 4'b0101; step();
    check("sw_rdyA", ch_data4, 32'hC0814001);
    ch_ready4 = 4'b1010; step();
    check("sw_rdyB_v", 32'(ch_valid4), 32'h7);
    check("sw_rdyB_d", 32'(ch_data4[23:0]), 32'h814101);
    ch_ready4 = 4'b0000;
    send4(8'h02); send4(8'h03);
    check("sw_ovf", 32'(ch_ovf4), 32'h1);

    // reset mid-operation; keep default strobe high through reset
    data = 8'h93; sb = 1'b1;
    rst = 1'b1; step();
    check("mid_valid4", 32'(ch_valid4), 32'h0);
    check("mid_ovf4",   32'(ch_ovf4),   32'h0);
    check("mid_data4",  ch_data4,       32'h0);
    step();
    rst = 1'b0;
    step(); step();
    check("rsb_e1", 32'(ch_valid), 32'h0);
    step();
    check("rsb_push", 32'(ch_valid), 32'h2);
    check("rsb_data", 32'(ch_data[15:8]), 32'h93);
    repeat (10) step();
    ch_ready = 2'b10; step(); ch_ready = 2'b00;
    check("rsb_once", 32'(ch_valid), 32'h0);
    sb = 1'b0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_router.md
# data_router

Parametrised strobe-driven data demultiplexer. Samples the incoming strobe through a two-flop synchroniser and detects its rising edge. On that edge it captures the parallel data word and routes it, by its most-significant select bits, into one of N per-channel FIFOs, each with a valid/ready output handshake. Sits between the external strobed byte bus and the downstream per-channel consumers; generalises the two-channel latch-and-pulse scheme to N channels with buffering, back-pressure and overflow reporting.

## Interface
- DATA_W, 8: data word width; must be greater than CH_SEL_W.
- CH_SEL_W, 1: select field width; channel count N_CH = 2**CH_SEL_W.
- DEPTH, 2: entries per channel FIFO; power of two, at least 2.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- DATA  in  DATA_W  input word; must be stable from strobe assertion until 3 clk edges later.
- data_sb  in  1  input strobe, asynchronous to clk, level; one word per low-to-high transition.
- ch_data  out  N_CH*DATA_W  channel i word at [i*DATA_W +: DATA_W]; the full word, including select bits.
- ch_valid  out  N_CH  channel i FIFO non-empty.
- ch_ready  in  N_CH  consumer i accepts the head word when ch_valid[i] & ch_ready[i] at a clk edge.
- ch_ovf  out  N_CH  sticky: a word for channel i was dropped because its FIFO was full.
- ovf_clr  in  1  one-cycle pulse clears all ch_ovf bits.

## Operation
- Synchroniser: s1 <= data_sb, s2 <= s1, s3 <= s2. push = s2 & ~s3; one push per strobe rising edge. A strobe high for many cycles produces exactly one push.
- Routing: sel = DATA[DATA_W-1 -: CH_SEL_W], sampled at the push edge. Only FIFO[sel] is written. Data is captured at the same edge.
- FIFO per channel: show-ahead; ch_data[i] is the head entry whenever ch_valid[i] = 1. When ch_valid[i] = 0, ch_data[i] holds its last value; it is not guaranteed.
  - Pop on ch_valid[i] & ch_ready[i].
  - Occupancy counter 0..DEPTH (width clog2(DEPTH)+1). Read and write pointers wrap modulo DEPTH.
- Push and pop on the same channel in the same cycle:
  - Not full: both happen; occupancy is unchanged.
  - Full: both happen; the pop frees the slot, the word is accepted, and ch_ovf is not set.
  - Empty: the pop is ignored because ch_valid = 0; the push happens.
- Full with no pop: the word is discarded and ch_ovf[sel] <= 1. FIFO contents and pointers are unchanged.
- ovf_clr and an overflow event in the same cycle: set wins; the bit stays 1. ovf_clr leaves no other state changed.
- Reset:
  - Clears s1, s2 and s3 to 0, all occupancies and pointers to 0, and ch_valid and ch_ovf to 0.
  - ch_data resets to 0.
  - If data_sb is already high while rst is asserted, the synchroniser shows that high right after reset (s1/s2/s3 follow it); s2 & ~s3 rises for one cycle and yields one push.
  - A word in flight in the synchroniser at reset is lost.

## Timing
- Let E0 be the first clk edge that samples data_sb = 1.
  - s2 = 1 after E1.
  - Push occurs at E2; DATA is sampled at E2.
  - ch_valid[sel] = 1 after E2 if the FIFO was empty. Latency is 3 edges.
- Strobe rate: data_sb must stay low for at least 2 clk cycles and high for at least 2 clk cycles; otherwise edges may be merged. No error is flagged.
- Pop throughput: 1 word per cycle per channel, independent across channels.
- Pop effect:
  - Pop at edge Ek: the next entry appears on ch_data[i] after Ek.
  - ch_valid falls after Ek if the popped entry was the last.
- All outputs are registered or decoded from registered state. There are no combinational paths from ch_ready to any output except through the clk edge.

## Structure
- Package data_router_pkg:
  - default parameter constants (DATA_W, CH_SEL_W, DEPTH);
  - the clog2 helper function;
  - localparam N_CH derivation.
- Sub-module chan_fifo:
  - parameters DATA_W and DEPTH;
  - ports clk, rst, push, din, pop_ready, dout, valid, full;
  - instantiated N_CH times in a generate loop.
- The top level holds the synchroniser, edge detect, select decode and ch_ovf registers.

## Test plan
- Basic route, defaults: with the FIFO empty, data_sb pulse with DATA = 8'h85 -> ch_valid[1] = 1 after exactly 3 edges, ch_data[1] = 8'h85; ch_valid[0] stays 0. Then DATA = 8'h12 -> goes to channel 0.
- Long strobe: data_sb held high for 20 cycles, DATA = 8'h81 -> exactly one push; occupancy of channel 1 = 1.
- Overflow, DEPTH = 2, ch_ready = 0: send 8'h01, 8'h02, 8'h03 -> the FIFO holds 01, 02 and ch_ovf[0] = 1. Pops return 01 then 02. ovf_clr -> ch_ovf[0] = 0.
- Full with simultaneous pop: channel 0 full (01, 02), ch_ready[0] = 1 held; push 8'h03 lands on the same edge as the pop of 01 -> 03 accepted, ch_ovf[0] = 0, pop order 02, 03.
- Parameter sweep, CH_SEL_W = 2, DATA_W = 8: words 8'h00, 8'h40, 8'h80, 8'hC0 -> each lands in channels 0..3 respectively. Independent ready patterns on each channel preserve per-channel order.
- Reset mid-operation:
  - rst asserted with words in 3 FIFOs and ch_ovf set -> all ch_valid = 0, ch_ovf = 0 and ch_data = 0 at the next edge.
  - With data_sb held high through reset -> exactly one push after rst deasserts.
